mux_n_pipe: RTL and testbench
=============================

// Module: mux_n_pipe
// PURPOSE
//  Parametrised N-input, WIDTH-bit selector with registered, flow-controlled output.
//  Successor to the 2:1 8-bit combinational data mux feeding Data Memory / ALU operands.
//  Adds valid/ready handshake, a 2-entry skid buffer and an out-of-range select error flag.
//  Sits between register-file/immediate sources and a stallable memory/ALU stage.
// PARAMETERS
//  WIDTH  8  data width of each input and of the output
//  N      4  number of inputs (2..16)
//  SW     2  select width, must satisfy 2**SW >= N
// PORTS
//  clk        in   1         clock, rising edge
//  rst_n      in   1         asynchronous reset, active low
//  e          in   N*WIDTH   inputs, input i = e[i*WIDTH +: WIDTH]
//  s          in   SW        select, sampled with the input beat
//  in_valid   in   1         producer has a beat (e, s)
//  in_ready   out  1         block accepts a beat this cycle
//  out        out  WIDTH     selected data, registered
//  out_valid  out  1         out holds a valid beat
//  out_ready  in   1         consumer accepts out this cycle
//  sel_err    out  1         sticky: a beat with s >= N was accepted
//  err_clr    in   1         synchronous clear of sel_err
// BEHAVIOUR
//  - Reset (rst_n=0, async): out=0, out_valid=0, skid empty, in_ready=1, sel_err=0.
//    Beats held at reset assertion are discarded; no partial beat after release.
//  - Accept when in_valid & in_ready; drain when out_valid & out_ready.
//  - Selected value v = e[s] if s < N, else v = 0 (WIDTH'b0) and sel_err set next edge.
//  - Latency: accepted beat appears on out the next cycle (1 clk), if main reg free or draining.
//  - Storage: main reg (drives out) + one skid reg. in_ready = !skid_full (registered, no
//    combinational path from out_ready to in_ready).
//  - States (by occupancy): EMPTY (0), ONE (main full), TWO (main + skid full).
//    EMPTY: accept -> ONE (main<=v).
//    ONE: accept & drain -> ONE (main<=v); accept only -> TWO (skid<=v);
//         drain only -> EMPTY; neither -> ONE, out stable.
//    TWO: in_ready=0; drain -> ONE (main<=skid); else hold.
//  - Ordering strictly FIFO; no beat dropped or duplicated; full throughput 1 beat/clk
//    when out_ready held high.
//  - out and out_valid stable while out_valid & !out_ready.
//  - sel_err: set on accept with s >= N; err_clr clears; same-cycle set & clear -> stays 1.
//  - s and e are don't-care when no accept occurs; no X propagation into registers.
//  - N == 2**SW: no out-of-range select possible, sel_err stays 0.
// TESTING
//  1 Reset: rst_n=0 mid-transfer in TWO -> out=0, out_valid=0, in_ready=1, sel_err=0 at once.
//  2 Select sweep N=4, WIDTH=8: e={8'h44,8'h33,8'h22,8'h11}, s=0..3, out_ready=1
//    -> out 11,22,33,44 on consecutive cycles, each 1 clk after accept.
//  3 Backpressure: out_ready=0, send 3 beats A,B,C -> A,B accepted, in_ready=0 on C;
//    release out_ready -> A,B,C emerge in order, C accepted 1 clk after A drains.
//  4 Throughput: in_valid=1, out_ready=1 for 16 cycles -> 16 beats out, in_ready never 0.
//  5 Error: N=3, SW=2, s=3 accepted -> out=8'h00, sel_err=1 next clk and sticky;
//    err_clr=1 -> sel_err=0; err_clr with new s=3 beat same cycle -> sel_err=1.
//  6 Random valid/ready toggling, 1000 beats vs. reference queue model -> zero mismatches.

Source files
------------

// File: rtl/mux_n_pipe.sv
// mux_n_pipe: N-input WIDTH-bit selector with registered valid/ready output
// and a one-entry skid register behind the output register.
`timescale 1ns/1ps
module mux_n_pipe #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SW    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] e,
  input  logic [SW-1:0]      s,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sel_err,
  input  logic               err_clr
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] v;
  logic             acc;
  logic             drn;
  logic             oob;
  logic             ld_main;
  logic             ld_skid;
  logic             from_skid;

  // ready depends only on the state register, never on out_ready
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign out       = main_q;
  assign acc       = in_valid & in_ready;
  assign drn       = out_valid & out_ready;
  assign oob       = (32'(s) >= N);

  // select e[s]; an out-of-range select yields zero
  always_comb begin
    v = '0;
    for (int i = 0; i < N; i++) begin
      if (s == SW'(i)) v = e[i*WIDTH +: WIDTH];
    end
  end

  // occupancy transitions and register load controls
  always_comb begin
    state_nx  = state;
    ld_main   = 1'b0;
    ld_skid   = 1'b0;
    from_skid = 1'b0;
    unique case (state)
      EMPTY: begin
        if (acc) begin
          state_nx = ONE;
          ld_main  = 1'b1;
        end
      end
      ONE: begin
        if (acc && drn) begin
          ld_main = 1'b1;
        end else if (acc) begin
          state_nx = TWO;
          ld_skid  = 1'b1;
        end else if (drn) begin
          state_nx = EMPTY;
        end
      end
      TWO: begin
        if (drn) begin
          state_nx  = ONE;
          ld_main   = 1'b1;
          from_skid = 1'b1;
        end
      end
      default: state_nx = EMPTY;
    endcase
  end

  // state and data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state <= state_nx;
      if (ld_main) main_q <= from_skid ? skid_q : v;
      if (ld_skid) skid_q <= v;
    end
  end

  // sticky select error; a new error wins over a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
    end else if (acc && oob) begin
      sel_err <= 1'b1;
    end else if (err_clr) begin
      sel_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_n_pipe.sv
// tb_mux_n_pipe: directed and random checks of mux_n_pipe (N=4 and N=3)
// with a queue scoreboard popped whenever an output beat is taken.
`timescale 1ns/1ps
module tb_mux_n_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] e4 = '0;
  logic [1:0]  s4 = '0;
  logic        iv4 = 1'b0, ir4, ov4, ordy4 = 1'b0, err4, clr4 = 1'b0;
  logic [7:0]  o4, x4 = '0;

  logic [23:0] e3 = '0;
  logic [1:0]  s3 = '0;
  logic        iv3 = 1'b0, ir3, ov3, ordy3 = 1'b0, err3, clr3 = 1'b0;
  logic [7:0]  o3, x3 = '0;

  mux_n_pipe #(.WIDTH(8), .N(4), .SW(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .e(e4), .s(s4),
    .in_valid(iv4), .in_ready(ir4), .out(o4), .out_valid(ov4),
    .out_ready(ordy4), .sel_err(err4), .err_clr(clr4)
  );

  mux_n_pipe #(.WIDTH(8), .N(3), .SW(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .e(e3), .s(s3),
    .in_valid(iv3), .in_ready(ir3), .out(o3), .out_valid(ov3),
    .out_ready(ordy3), .sel_err(err3), .err_clr(clr3)
  );

  int pass = 0;
  int total = 0;
  int pops4 = 0;
  int cyc = 0;
  logic [7:0] q4[$];
  logic [7:0] q3[$];
  logic [7:0] swx[4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] x);
    total++;
    if (a === x) pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, a, x);
  endtask

  task automatic send4(input logic [31:0] ev, input logic [1:0] sv,
                       input logic [7:0] xv);
    e4 = ev; s4 = sv; x4 = xv; iv4 = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ir4) begin
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    total++;
    $display("FAIL send4_timeout: in_ready stuck at %0b", ir4);
  endtask

  task automatic send3(input logic [23:0] ev, input logic [1:0] sv,
                       input logic [7:0] xv);
    e3 = ev; s3 = sv; x3 = xv; iv3 = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ir3) begin
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    total++;
    $display("FAIL send3_timeout: in_ready stuck at %0b", ir3);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, p0, sent, guard;
    logic acc_last;
    logic [31:0] ev;
    logic [1:0] sv;

    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (ov4 && ordy4) begin
            if (q4.size() == 0) begin
              total++;
              $display("FAIL sb4: unexpected beat %0h", o4);
            end else begin
              chk("sb4", o4, q4.pop_front());
              pops4++;
            end
          end
          if (iv4 && ir4) q4.push_back(x4);
          if (ov3 && ordy3) begin
            if (q3.size() == 0) begin
              total++;
              $display("FAIL sb3: unexpected beat %0h", o3);
            end else begin
              chk("sb3", o3, q3.pop_front());
            end
          end
          if (iv3 && ir3) q3.push_back(x3);
        end
      end
    join_none

    // power-on reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst0_out", o4, 0);
    chk("rst0_ovalid", ov4, 0);
    chk("rst0_iready", ir4, 1);
    chk("rst0_err", err4, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // select sweep with 1-cycle latency
    ordy4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send4(32'h44332211, 2'(i), swx[i]);
      chk("lat_valid", ov4, 1);
      chk("lat_out", o4, swx[i]);
    end
    iv4 = 1'b0;
    idle(3);

    // backpressure: A,B fill, C blocked
    ordy4 = 1'b0;
    send4(32'h44332211, 2'd0, 8'h11);
    send4(32'h44332211, 2'd1, 8'h22);
    e4 = 32'h44332211; s4 = 2'd2; x4 = 8'h33; iv4 = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("bp_iready", ir4, 0);
      chk("bp_ovalid", ov4, 1);
      chk("bp_hold", o4, 8'h11);
    end
    @(posedge clk); #1;
    ordy4 = 1'b1;
    @(negedge clk);
    chk("bp_still_full", ir4, 0);
    @(posedge clk); #1;
    chk("bp_reopen", ir4, 1);
    chk("bp_b_out", o4, 8'h22);
    @(negedge clk);
    @(posedge clk); #1;
    iv4 = 1'b0;
    chk("bp_c_out", o4, 8'h33);
    idle(3);

    // throughput: 16 beats in 16 cycles
    p0 = pops4;
    c0 = cyc;
    for (int i = 0; i < 16; i++) send4(32'h44332211, 2'(i % 4), swx[i % 4]);
    chk("tp_cycles", cyc - c0, 16);
    iv4 = 1'b0;
    idle(4);
    chk("tp_beats", pops4 - p0, 16);

    // select error on the N=3 instance
    ordy3 = 1'b1;
    send3(24'h332211, 2'd3, 8'h00);
    chk("err_set", err3, 1);
    chk("err_out", o3, 8'h00);
    iv3 = 1'b0;
    idle(3);
    chk("err_sticky", err3, 1);
    clr3 = 1'b1;
    idle(1);
    clr3 = 1'b0;
    chk("err_clr", err3, 0);
    send3(24'h332211, 2'd2, 8'h33);
    iv3 = 1'b0;
    chk("err_inrange", err3, 0);
    chk("err_inrange_out", o3, 8'h33);
    clr3 = 1'b1;
    send3(24'h332211, 2'd3, 8'h00);
    clr3 = 1'b0;
    iv3 = 1'b0;
    chk("err_set_clr", err3, 1);
    idle(3);

    // async reset while full
    ordy4 = 1'b0;
    ordy3 = 1'b0;
    send4(32'h44332211, 2'd3, 8'h44);
    send4(32'h44332211, 2'd2, 8'h33);
    iv4 = 1'b0;
    send3(24'h332211, 2'd3, 8'h00);
    iv3 = 1'b0;
    chk("pre_rst_full", ir4, 0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out", o4, 0);
    chk("rst_ovalid", ov4, 0);
    chk("rst_iready", ir4, 1);
    chk("rst_err3", err3, 0);
    chk("rst_ovalid3", ov3, 0);
    q4.delete();
    q3.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    chk("post_rst_ovalid", ov4, 0);

    // random valid/ready traffic
    p0 = pops4;
    sent = 0;
    guard = 0;
    acc_last = 1'b0;
    while (sent < 1000 && guard < 20000) begin
      @(posedge clk); #1;
      guard++;
      ordy4 = 1'($urandom_range(0, 1));
      if (!iv4 || acc_last) begin
        if ($urandom_range(0, 2) != 0) begin
          ev = $urandom;
          sv = 2'($urandom_range(0, 3));
          e4 = ev; s4 = sv; x4 = ev[sv*8 +: 8];
          iv4 = 1'b1;
        end else begin
          iv4 = 1'b0;
          e4 = $urandom;
        end
      end
      @(negedge clk);
      acc_last = iv4 && ir4;
      if (acc_last) sent++;
    end
    @(posedge clk); #1;
    iv4 = 1'b0;
    ordy4 = 1'b1;
    for (int k = 0; k < 50 && q4.size() != 0; k++) idle(1);
    chk("rand_sent", sent, 1000);
    chk("rand_drain", q4.size(), 0);
    chk("rand_beats", pops4 - p0, 1000);
    chk("rand_no_err", err4, 0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
